byte_serializer: RTL and testbench
==================================

Name: byte_serializer

Overview:
- Upstream feeder for the serial sequence detector (seqdec_53) and for any other single-bit-input detector in the homework set.
- Accepts parallel bytes on a valid/ready handshake and buffers them in a small FIFO.
- Shifts each byte out MSB-first, one bit per Clk, on a serial stream. Back-to-back bytes are gapless, so 8-bit patterns spanning byte boundaries stay detectable downstream.

Parameters:
- DEPTH, 4, byte FIFO entries; power of two, >= 2.
- BYTE_W, 8, bits per input word; fixed at 8 for this revision.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InData  input  BYTE_W  parallel byte to send.
- InValid  input  1  InData valid this cycle.
- InReady  output  1  FIFO can accept a byte this cycle.
- Out  output  1  serial bit; connects to detector InA.
- OutValid  output  1  Out carries a real data bit.
- FrameStart  output  1  high while Out is bit 7 of a byte.
- Busy  output  1  shifter active or FIFO non-empty.

Behaviour:
- Reset: Reset is synchronous, active-high; clock is Clk. While Reset is sampled high:
  - FIFO pointers and count clear to 0.
  - Shift register clears to 8'h00; bit counter clears to 0; state = IDLE.
  - All outputs 0 except InReady, which is 1 starting the cycle after the Reset edge.
- Reset mid-byte: the in-flight byte and all queued bytes are discarded. No residual bits appear after Reset deasserts.
- Accept rule:
  - A byte is accepted on a rising edge when InValid && InReady.
  - InReady = (count != DEPTH), derived combinationally from registered count only.
  - A write is refused when full, even if a pop occurs on the same edge.
- State IDLE:
  - Out=0, OutValid=0, FrameStart=0.
  - If FIFO is non-empty at an edge: pop head into shifter, bitcnt=7, go to SHIFT.
- State SHIFT:
  - Out = shifter[7]; OutValid=1; FrameStart = (bitcnt==7).
  - Each edge: shift left by 1 and decrement bitcnt.
  - At the edge where bitcnt==0:
    - if FIFO non-empty (count as registered before this edge), pop next byte, bitcnt=7, stay in SHIFT (no gap);
    - else go to IDLE.
- Latency:
  - A byte accepted at edge N into an empty, idle block is loaded at edge N+1.
  - Its bit 7 is on Out during the cycle after edge N+1; bit 0 is on Out after edge N+8.
- Simultaneous push and pop on one edge: count unchanged; both pointers advance.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Out is forced 0 whenever OutValid=0, so an idle stream reads as zeros downstream.
- Busy = (state==SHIFT) || (count!=0).

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - Each byte is followed by one extra slot carrying the even-parity bit (XOR of the 8 data bits), with OutValid=1 and FrameStart=0.
  - Frame length is 9 cycles; bitcnt runs 8..0.
  - Gapless chaining applies after the parity slot.
- Undefined: 8-cycle frames exactly as above; no parity logic synthesized.

Decomposition:
- Shared package seqdec_pkg:
  - BYTE_W constant.
  - Serializer state typedef (IDLE, SHIFT).
  - Pattern constant SEQ_MATCH = 8'h53 for reuse by detector benches.
- One sub-module: ser_fifo (DEPTH x BYTE_W synchronous FIFO; push/pop/full/empty/count).
- Shift engine stays in byte_serializer.

Test Plan:
- Single byte: Reset, then InData=8'h53 with one-cycle InValid -> Out = 0,1,0,1,0,0,1,1 over 8 consecutive cycles starting 2 cycles after acceptance. OutValid high exactly 8 cycles; FrameStart high in the first of them only; then IDLE with Out=0.
- Back-to-back: push 8'h85 then 8'h97 on consecutive edges -> 16 contiguous valid bits 1000_0101_1001_0111, no gap; FrameStart on bits 0 and 8.
- Backpressure (DEPTH=4): hold InValid with new data every cycle -> exactly 5 bytes accepted before InReady drops (1 in shifter, 4 queued). InReady rises the cycle after the next pop; byte order is preserved on Out.
- Reset mid-operation: assert Reset during bit 3 of 8'h53 with 2 bytes queued -> next cycle Out=0, OutValid=0, Busy=0, InReady=1. No further valid bits until a new push.
- Chain with seqdec_53: stream bytes 00 28 85 0A 97 2E 42 84 53 53 28 A0 85 97 42 53 -> detector Out pulses exactly where the preceding 8 serialized bits equal 8'h53. Bench checker reports zero ERRORCHECK lines.
- SER_PARITY_EN defined: push 8'h53 -> 9 valid bits 0,1,0,1,0,0,1,1,0. Push 8'h97 -> trailing parity bit 1.

Source files
------------

// File: rtl/seqdec_pkg.sv
// Shared constants and types for the byte serializer and the serial detectors it feeds.
// No logic of its own; SEQ_MATCH is the pattern the downstream detector benches look for.
// BYTE_W is fixed at 8 for this revision.
package seqdec_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SEQ_MATCH = 8'h53;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Even parity over one byte: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Byte-in / bit-out bundle between a byte producer and the serializer.
// master drives the parallel byte side; slave is the serializer itself.
// InReady gates acceptance; the serial side has no backpressure.
interface byte_serializer_if;
  import seqdec_pkg::*;

  logic [BYTE_W-1:0] InData;
  logic              InValid;
  logic              InReady;
  logic              Out;
  logic              OutValid;
  logic              FrameStart;
  logic              Busy;

  modport master (
    output InData, InValid,
    input  InReady, Out, OutValid, FrameStart, Busy
  );

  modport slave (
    input  InData, InValid,
    output InReady, Out, OutValid, FrameStart, Busy
  );

endinterface

// File: rtl/ser_fifo.sv
// DEPTH x WIDTH synchronous FIFO with registered count; head is read combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push ignored while full (even with a same-edge pop); pop ignored while empty.
module ser_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/byte_serializer.sv
// Buffers parallel bytes and shifts them out MSB-first, one bit per Clk, gapless back-to-back.
// Latency: byte accepted at edge N loads at N+1; bit 7 on Out after N+1. SER_PARITY_EN adds a trailing even-parity slot.
// Backpressure: InReady = FIFO not full (registered count); serial output is never stalled.
module byte_serializer
  import seqdec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  byte_serializer_if.slave  bus
);

`ifdef SER_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  ser_state_e          state_q, state_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [3:0]          bitcnt_q, bitcnt_d;
`ifdef SER_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic                fifo_pop;
  logic [BYTE_W-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  logic                load;
  logic                out_bit;
  logic                out_vld;
  logic                frame_start;

  ser_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .Clk        (Clk),
    .Reset      (Reset),
    .push_i     (bus.InValid),
    .push_dat_i (bus.InData),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Shift engine state register; reset discards any byte in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
`ifdef SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state and serial outputs; the last slot of a frame chains straight into the next byte.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
`ifdef SER_PARITY_EN
    parity_d    = parity_q;
`endif
    load        = 1'b0;
    fifo_pop    = 1'b0;
    out_bit     = 1'b0;
    out_vld     = 1'b0;
    frame_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      SHIFT: begin
        out_vld     = 1'b1;
        frame_start = (bitcnt_q == LAST_BIT);
`ifdef SER_PARITY_EN
        out_bit     = (bitcnt_q == 4'd0) ? parity_q : shift_q[BYTE_W-1];
`else
        out_bit     = shift_q[BYTE_W-1];
`endif
        shift_d     = {shift_q[BYTE_W-2:0], 1'b0};
        bitcnt_d    = bitcnt_q - 4'd1;
        if (bitcnt_q == 4'd0) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d  = IDLE;
            bitcnt_d = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_head;
      bitcnt_d = LAST_BIT;
      state_d  = SHIFT;
`ifdef SER_PARITY_EN
      parity_d = even_parity(fifo_head);
`endif
    end
  end

  assign bus.InReady    = !fifo_full;
  assign bus.Out        = out_bit;
  assign bus.OutValid   = out_vld;
  assign bus.FrameStart = frame_start;
  assign bus.Busy       = (state_q == SHIFT) || (fifo_count != '0);

endmodule

// File: tb/tb_byte_serializer.sv
module tb_byte_serializer;
  import seqdec_pkg::*;

  localparam int DEPTH = 4;
`ifdef SER_PARITY_EN
  localparam int          FRAME      = 9;
  localparam logic [63:0] EXP_SINGLE = 64'h0A6;
  localparam logic [63:0] EXP_S_FS   = 64'h100;
  localparam logic [63:0] EXP_B2B    = 64'h2172F;
  localparam logic [63:0] EXP_B2B_FS = 64'h20100;
`else
  localparam int          FRAME      = 8;
  localparam logic [63:0] EXP_SINGLE = 64'h53;
  localparam logic [63:0] EXP_S_FS   = 64'h80;
  localparam logic [63:0] EXP_B2B    = 64'h8597;
  localparam logic [63:0] EXP_B2B_FS = 64'h8080;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  byte_serializer_if sif ();

  byte_serializer #(.DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (sif)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit model_on = 1'b0;

  // Reference: a queue of accepted bytes and a queue of bits still to emit in the current frame.
  bit [7:0] m_fifo[$];
  bit       m_cur[$];

  // Captured stream (valid bits only) for the literal checks.
  bit cap[$];
  bit capfs[$];
  int capcyc[$];

  always @(posedge Clk) begin : model
    bit       acc;
    bit [7:0] b;
    cyc++;
    if (Reset === 1'b1) begin
      m_fifo.delete();
      m_cur.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      acc = (sif.InValid === 1'b1) && (m_fifo.size() != DEPTH);
      if (m_cur.size() > 1) begin
        void'(m_cur.pop_front());
      end else begin
        m_cur.delete();
        if (m_fifo.size() != 0) begin
          b = m_fifo.pop_front();
          for (int i = 7; i >= 0; i--) m_cur.push_back(b[i]);
`ifdef SER_PARITY_EN
          m_cur.push_back(^b);
`endif
        end
      end
      if (acc) m_fifo.push_back(sif.InData);
    end
  end

  always @(negedge Clk) begin : compare
    logic [4:0] act;
    logic [4:0] exp;
    if (model_on) begin
      exp[4] = (m_cur.size() != 0);
      exp[3] = (m_cur.size() != 0) ? m_cur[0] : 1'b0;
      exp[2] = (m_cur.size() == FRAME);
      exp[1] = (m_fifo.size() != DEPTH);
      exp[0] = (m_cur.size() != 0) || (m_fifo.size() != 0);
      act = {sif.OutValid, sif.Out, sif.FrameStart, sif.InReady, sif.Busy};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL stream cyc=%0d {vld,out,fs,rdy,busy} got=%b want=%b", cyc, act, exp);
      end
      if (sif.OutValid === 1'b1) begin
        cap.push_back(sif.Out);
        capfs.push_back(sif.FrameStart);
        capcyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int from, input int n, input bit use_fs);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (from + i < cap.size()) v = {v[62:0], use_fs ? capfs[from+i] : cap[from+i]};
      else                       v = {v[62:0], 1'b0};
    end
    return v;
  endfunction

  // Drives each byte until accepted; reports how many went in before the first refusal.
  task automatic push_bytes(input bit [7:0] bs[$], input int budget,
                            output int refused_after, output int first_acc);
    int idx;
    int spent;
    bit r;
    idx = 0; spent = 0; refused_after = -1; first_acc = -1;
    while (idx < bs.size() && spent < budget) begin
      sif.InValid = 1'b1;
      sif.InData  = bs[idx];
      @(negedge Clk);
      r = sif.InReady;
      if (!r && refused_after < 0) refused_after = idx;
      @(posedge Clk); #1;
      if (r) begin
        if (idx == 0) first_acc = cyc;
        idx++;
      end
      spent++;
    end
    sif.InValid = 1'b0;
    if (idx < bs.size()) begin
      bad++; total++;
      $display("FAIL push_timeout got=%0d want=%0d bytes", idx, bs.size());
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge Clk);
    while (!(sif.Busy === 1'b0 && sif.OutValid === 1'b0) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (n >= budget) begin
      bad++; total++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
    @(posedge Clk); #1;
  endtask

  function automatic int stream_errs(input int from, input bit [7:0] bs[$]);
    bit want[$];
    int e;
    foreach (bs[k]) begin
      for (int i = 7; i >= 0; i--) want.push_back(bs[k][i]);
`ifdef SER_PARITY_EN
      want.push_back(^bs[k]);
`endif
    end
    e = (cap.size() - from == want.size()) ? 0 : 1;
    foreach (want[i]) if (from + i >= cap.size() || cap[from+i] != want[i]) e++;
    return e;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running want=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit [7:0] q[$];
    int base, refused, acc, n;

    sif.InValid = 1'b0;
    sif.InData  = 8'h00;
    Reset       = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outputs", {sif.Out, sif.OutValid, sif.FrameStart, sif.Busy, sif.InReady}, 5'b00001);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Single byte 8'h53
    base = cap.size();
    q = '{8'h53};
    push_bytes(q, 20, refused, acc);
    wait_idle(40);
    chk("single_bits", pack(base, FRAME, 1'b0), EXP_SINGLE);
    chk("single_fs", pack(base, FRAME, 1'b1), EXP_S_FS);
    chk("single_len", 64'(cap.size() - base), 64'(FRAME));
    chk("single_latency", 64'(capcyc[base] - acc), 64'd1);

    // Back-to-back 85, 97: gapless
    base = cap.size();
    q = '{8'h85, 8'h97};
    push_bytes(q, 20, refused, acc);
    wait_idle(60);
    chk("b2b_bits", pack(base, 2*FRAME, 1'b0), EXP_B2B);
    chk("b2b_fs", pack(base, 2*FRAME, 1'b1), EXP_B2B_FS);
    chk("b2b_contiguous", 64'(capcyc[base + 2*FRAME - 1] - capcyc[base]), 64'(2*FRAME - 1));

    // Backpressure: one in the shifter plus DEPTH queued before InReady drops
    base = cap.size();
    q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    push_bytes(q, 200, refused, acc);
    chk("bp_accept_before_full", 64'(refused), 64'd5);
    wait_idle(200);
    chk("bp_order", 64'(stream_errs(base, q)), 64'd0);

    // Reset during bit 3 of 8'h53 with two bytes queued
    base = cap.size();
    q = '{8'h53, 8'h11, 8'h22};
    push_bytes(q, 20, refused, acc);
    n = 0;
    while (cap.size() < base + 4 && n < 40) begin
      @(posedge Clk);
      n++;
    end
    if (n >= 40) begin
      bad++; total++;
      $display("FAIL mid_wait got=%0d want=%0d bits", cap.size() - base, 4);
    end
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk); #1;
    chk("reset_mid_outputs", {sif.Out, sif.OutValid, sif.FrameStart, sif.Busy, sif.InReady}, 5'b00001);
    chk("reset_mid_bits", pack(base, 5, 1'b0), 64'h0A);
    repeat (20) @(posedge Clk);
    #1;
    chk("reset_no_residue", 64'(cap.size() - base), 64'd5);

    // Detector feed stream
    base = cap.size();
    q = '{8'h00, 8'h28, 8'h85, 8'h0A, 8'h97, 8'h2E, 8'h42, 8'h84,
          8'h53, 8'h53, 8'h28, 8'hA0, 8'h85, 8'h97, 8'h42, 8'h53};
    push_bytes(q, 400, refused, acc);
    wait_idle(400);
    chk("chain_stream", 64'(stream_errs(base, q)), 64'd0);
    chk("chain_len", 64'(cap.size() - base), 64'(16*FRAME));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
